// File: rtl/matrix_det_pkg.sv
// Shared types and constants for the 2x2 determinant stage.
// Optional singular flag is enabled by defining MATRIX_DET_SINGULAR_EN.
package matrix_det_pkg;

    localparam int ENTRY_W_DEF = 5;

    // Entry slot index inside z_in; bit offset is slot * ENTRY_W.
    localparam int AZ_POS = 0;
    localparam int BZ_POS = 1;
    localparam int CZ_POS = 2;
    localparam int DZ_POS = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL_AD = 3'd1,
        ST_MUL_BC = 3'd2,
        ST_SUB    = 3'd3,
        ST_DONE   = 3'd4
    } det_state_t;

endpackage

// File: rtl/matrix_det_if.sv
// Valid/ready bundle between the matrix multiplier, the determinant stage and its consumer.
// The singular signal exists only when MATRIX_DET_SINGULAR_EN is defined.
interface matrix_det_if
    import matrix_det_pkg::*;
#(
    parameter int ENTRY_W = ENTRY_W_DEF
) ();

    logic [4*ENTRY_W-1:0] z_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*ENTRY_W:0]   det_out;
    logic                 out_valid;
    logic                 out_ready;
`ifdef MATRIX_DET_SINGULAR_EN
    logic                 singular;

    modport slave  (input  z_in, in_valid, out_ready,
                    output in_ready, det_out, out_valid, singular);
    modport master (output z_in, in_valid, out_ready,
                    input  in_ready, det_out, out_valid, singular);
`else
    modport slave  (input  z_in, in_valid, out_ready,
                    output in_ready, det_out, out_valid);
    modport master (output z_in, in_valid, out_ready,
                    input  in_ready, det_out, out_valid);
`endif

endinterface

// File: rtl/matrix_det_seq_mult.sv
// Unsigned W x W shift-add multiplier, one multiplier bit per cycle.
// done and product are valid together in the cycle of the last iteration.
module seq_mult #(
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CNT_W = $clog2(W + 1);

    logic [2*W-1:0]   mcand_r;
    logic [W-1:0]     mplier_r;
    logic [2*W-1:0]   acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [2*W-1:0]   partial_s;
    logic [2*W-1:0]   sum_s;

    assign partial_s = mplier_r[0] ? mcand_r : {(2*W){1'b0}};
    assign sum_s     = acc_r + partial_s;
    assign done      = busy_r && (cnt_r == CNT_W'(W - 1));
    // The final sum is handed out combinationally so a new start can reuse the registers on the same edge.
    assign product   = sum_s;

    // Operand load on start, otherwise one shift-add iteration per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{W{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= {(2*W){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
            busy_r   <= !done;
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/matrix_det.sv
// Determinant Az*Dz - Bz*Cz of a packed 2x2 matrix using one shared sequential multiplier.
// Define MATRIX_DET_SINGULAR_EN to add the registered singular flag.
module matrix_det
    import matrix_det_pkg::*;
#(
    parameter int ENTRY_W = ENTRY_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    matrix_det_if.slave bus
);

    localparam int DET_W  = 2*ENTRY_W + 1;
    localparam int PROD_W = 2*ENTRY_W;

    det_state_t         state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [DET_W-1:0]   det_r;
    logic [ENTRY_W-1:0] b_r;
    logic [ENTRY_W-1:0] c_r;
    logic [PROD_W-1:0]  p1_r;
    logic [PROD_W-1:0]  p2_r;
    logic               mul_start_s;
    logic [ENTRY_W-1:0] mul_a_s;
    logic [ENTRY_W-1:0] mul_b_s;
    logic               mul_done_s;
    logic [PROD_W-1:0]  mul_prod_s;
    logic               accept_s;

    assign accept_s      = bus.in_valid && in_ready_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.det_out   = det_r;

    // Az*Dz starts straight from z_in on the accepting edge; Bz*Cz starts as the first product finishes.
    always_comb begin
        mul_start_s = 1'b0;
        mul_a_s     = b_r;
        mul_b_s     = c_r;
        if (state_r == ST_IDLE) begin
            mul_start_s = accept_s;
            mul_a_s     = bus.z_in[AZ_POS*ENTRY_W +: ENTRY_W];
            mul_b_s     = bus.z_in[DZ_POS*ENTRY_W +: ENTRY_W];
        end else if (state_r == ST_MUL_AD) begin
            mul_start_s = mul_done_s;
        end else begin
            mul_start_s = 1'b0;
        end
    end

    seq_mult #(.W(ENTRY_W)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .a       (mul_a_s),
        .b       (mul_b_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

`ifdef MATRIX_DET_SINGULAR_EN
    logic singular_r;

    assign bus.singular = singular_r;

    // Singular flag is captured alongside the determinant and held with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            singular_r <= 1'b0;
        end else if (state_r == ST_SUB) begin
            singular_r <= (p1_r == p2_r);
        end else begin
            singular_r <= singular_r;
        end
    end
`endif

    // Sequencing FSM: accept, two products, subtract, then hold the result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            det_r       <= {DET_W{1'b0}};
            b_r         <= {ENTRY_W{1'b0}};
            c_r         <= {ENTRY_W{1'b0}};
            p1_r        <= {PROD_W{1'b0}};
            p2_r        <= {PROD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        b_r        <= bus.z_in[BZ_POS*ENTRY_W +: ENTRY_W];
                        c_r        <= bus.z_in[CZ_POS*ENTRY_W +: ENTRY_W];
                        in_ready_r <= 1'b0;
                        state_r    <= ST_MUL_AD;
                    end
                end
                ST_MUL_AD: begin
                    if (mul_done_s) begin
                        p1_r    <= mul_prod_s;
                        state_r <= ST_MUL_BC;
                    end
                end
                ST_MUL_BC: begin
                    if (mul_done_s) begin
                        p2_r    <= mul_prod_s;
                        state_r <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    // One extra bit over the product width makes the difference exact.
                    det_r       <= {1'b0, p1_r} - {1'b0, p2_r};
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_det.sv
// Self-checking bench for matrix_det with a scoreboard of expected determinants.
// Singular checks are compiled in when MATRIX_DET_SINGULAR_EN is defined.
module tb_matrix_det;

    typedef struct packed {
        logic [10:0] det;
        logic        sing;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    matrix_det_if #(.ENTRY_W(5)) bus ();

    matrix_det #(.ENTRY_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] pack(input int a, input int b, input int c, input int d);
        return {d[4:0], c[4:0], b[4:0], a[4:0]};
    endfunction

    function automatic exp_t model(input logic [19:0] z);
        int   a, b, c, d, v;
        exp_t e;
        a = int'(z[4:0]);
        b = int'(z[9:5]);
        c = int'(z[14:10]);
        d = int'(z[19:15]);
        v = a*d - b*c;
        e.det  = v[10:0];
        e.sing = (a*d == b*c);
        return e;
    endfunction

    task automatic drive_accept(input logic [19:0] z);
        @(negedge clk);
        bus.z_in     = z;
        bus.in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(z));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until out_valid, and in_ready highs seen meanwhile.
    task automatic wait_valid(output int lat, output int rdy_bad);
        lat = 0;
        rdy_bad = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry available");
            errors++;
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.z_in      = 20'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); errors++;
        end
        checks++;
        if (bus.det_out !== 11'd0) begin
            $display("FAIL reset_det_out: got %h want 000", bus.det_out); errors++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); errors++;
        end
`ifdef MATRIX_DET_SINGULAR_EN
        checks++;
        if (bus.singular !== 1'b0) begin
            $display("FAIL reset_singular: got %b want 0", bus.singular); errors++;
        end
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   lat, bad;
        exp_t e;
        bus.out_ready = 1'b1;
        drive_accept(20'h20823);
        wait_valid(lat, bad);
        pop_exp(e);
        checks++;
        if (lat != 11) begin
            $display("FAIL basic_latency: got %0d want 11", lat); errors++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL basic_in_ready_busy: in_ready high %0d times want 0", bad); errors++;
        end
        checks++;
        if (bus.det_out !== e.det) begin
            $display("FAIL basic_det: got %h want %h", bus.det_out, e.det); errors++;
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL basic_in_ready_done: got %b want 0", bus.in_ready); errors++;
        end
`ifdef MATRIX_DET_SINGULAR_EN
        checks++;
        if (bus.singular !== e.sing) begin
            $display("FAIL basic_singular: got %b want %b", bus.singular, e.sing); errors++;
        end
`endif
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL basic_after_handshake: out_valid=%b in_ready=%b want 0/1",
                     bus.out_valid, bus.in_ready); errors++;
        end
        checks++;
        if (bus.det_out !== e.det) begin
            $display("FAIL basic_det_hold: got %h want %h", bus.det_out, e.det); errors++;
        end
    endtask

    task automatic test_negative();
        int   lat, bad;
        exp_t e;
        bus.out_ready = 1'b1;
        drive_accept(pack(0, 31, 31, 0));
        wait_valid(lat, bad);
        pop_exp(e);
        checks++;
        if (lat != 11 || bad != 0) begin
            $display("FAIL neg_timing: latency %0d in_ready_hits %0d want 11/0", lat, bad); errors++;
        end
        checks++;
        if (bus.det_out !== e.det) begin
            $display("FAIL neg_det: got %h want %h", bus.det_out, e.det); errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_singular();
        int   lat, bad;
        exp_t e;
        bus.out_ready = 1'b1;
        drive_accept(pack(2, 4, 3, 6));
        wait_valid(lat, bad);
        pop_exp(e);
        checks++;
        if (lat != 11) begin
            $display("FAIL sing_latency: got %0d want 11", lat); errors++;
        end
        checks++;
        if (bus.det_out !== e.det) begin
            $display("FAIL sing_det: got %h want %h", bus.det_out, e.det); errors++;
        end
`ifdef MATRIX_DET_SINGULAR_EN
        checks++;
        if (bus.singular !== e.sing) begin
            $display("FAIL sing_flag: got %b want %b", bus.singular, e.sing); errors++;
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int   lat, bad, hold_bad, idle_bad;
        exp_t e;
        bus.out_ready = 1'b0;
        drive_accept(pack(31, 0, 0, 31));
        wait_valid(lat, bad);
        pop_exp(e);
        checks++;
        if (lat != 11) begin
            $display("FAIL bp_latency: got %0d want 11", lat); errors++;
        end
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.det_out !== e.det || bus.in_ready !== 1'b0) hold_bad++;
            if (i == 1) begin
                bus.z_in     = pack(1, 2, 3, 4);
                bus.in_valid = 1'b1;
            end
            if (i == 3) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (hold_bad != 0) begin
            $display("FAIL bp_hold: %0d unstable cycles, det=%h want %h held", hold_bad, bus.det_out, e.det);
            errors++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL bp_consume: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
            errors++;
        end
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) idle_bad++;
            @(negedge clk);
        end
        checks++;
        if (idle_bad != 0) begin
            $display("FAIL bp_second_ignored: %0d busy cycles after consume want 0", idle_bad); errors++;
        end
    endtask

    task automatic test_reset_abort();
        int   lat, bad, early;
        exp_t e;
        bus.out_ready = 1'b1;
        drive_accept(20'h20823);
        early = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) early++;
        end
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.det_out !== 11'd0) begin
            $display("FAIL abort_reset_values: out_valid=%b in_ready=%b det=%h want 0/1/000",
                     bus.out_valid, bus.in_ready, bus.det_out); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            $display("FAIL abort_no_pulse: %0d bad cycles want 0", early); errors++;
        end
        drive_accept(pack(31, 0, 0, 31));
        wait_valid(lat, bad);
        pop_exp(e);
        checks++;
        if (lat != 11 || bad != 0) begin
            $display("FAIL abort_next_timing: latency %0d in_ready_hits %0d want 11/0", lat, bad); errors++;
        end
        checks++;
        if (bus.det_out !== e.det) begin
            $display("FAIL abort_next_det: got %h want %h", bus.det_out, e.det); errors++;
        end
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.z_in      = 20'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_singular();
        test_backpressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
